ahb_slave_ctrl: RTL and testbench

- AHB-Lite slave control stage that sits directly upstream of the slave read-data mux.
- Samples the address phase, checks it against the 4-byte register map, and inserts wait states.
- Drives the read-select and read-strobe into the read-data stage, and produces hreadyout/hresp, including the two-cycle ERROR response.
- Also issues write strobes for the writable payload registers and holds a sticky error-status code that the read path reports.

---
 rtl/ahb_slave_ctrl.sv | 173 +++++++++++++++++
 tb/tb_ahb_slave_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_slave_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : ahb_slave_ctrl
// Brief   : AHB-Lite slave control stage: address check, wait states,
//           two-cycle ERROR response, read/write strobes, sticky error code.
// Revision: 1.0 - initial release
// ============================================================================
module ahb_slave_ctrl #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic              hclk,
  input  logic              hreset_n,
  input  logic              hsel_x,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic              hready,
  input  logic [7:0]        hwdata,
  output logic              hreadyout,
  output logic              hresp,
  output logic [1:0]        read_select,
  output logic              rd_strobe,
  output logic              wr_en,
  output logic [1:0]        wr_addr,
  output logic [7:0]        wr_data,
  output logic [1:0]        err_status
);

  localparam logic [2:0] c_IDLE = 3'd0;
  localparam logic [2:0] c_WAIT = 3'd1;
  localparam logic [2:0] c_DATA = 3'd2;
  localparam logic [2:0] c_ERR1 = 3'd3;
  localparam logic [2:0] c_ERR2 = 3'd4;

  localparam logic [1:0] c_NONSEQ    = 2'b10;
  localparam logic [1:0] c_SEQ       = 2'b11;
  localparam logic [3:0] c_WAIT_INIT = 4'(WAIT_STATES - 1);

  logic [2:0] r_state;
  logic [2:0] w_next_state;
  logic [3:0] r_cnt;
  logic [3:0] w_next_cnt;

  logic       w_can_accept;
  logic       w_accept;
  logic [1:0] w_code;
  logic       w_legal;
  logic       w_data_end;

  logic [1:0] r_addr_q;
  logic       r_write_q;
  logic [2:0] r_size_q;
  logic [1:0] r_read_select;
  logic       r_rd_strobe;
  logic       r_wr_en;
  logic [1:0] r_wr_addr;
  logic [7:0] r_wr_data;
  logic [1:0] r_err_status;

  // A new address phase can only be taken while this slave reports ready.
  assign w_can_accept = (r_state == c_IDLE) || (r_state == c_DATA) || (r_state == c_ERR2);
  assign w_accept     = w_can_accept && hsel_x && hready &&
                        ((htrans == c_NONSEQ) || (htrans == c_SEQ));
  assign w_legal      = (w_code == 2'd0);
  assign w_data_end   = (r_state == c_DATA);

  always_comb begin
    w_code = 2'd0;
    if (haddr[ADDR_W-1:2] != '0) begin
      w_code = 2'd1;
    end else if (hsize != 3'd0) begin
      w_code = 2'd2;
    end else if (hwrite && ((haddr[1:0] == 2'd0) || (haddr[1:0] == 2'd3))) begin
      w_code = 2'd3;
    end
  end

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      r_state <= c_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    case (r_state)
      c_IDLE, c_DATA, c_ERR2: begin
        if (w_accept && w_legal) begin
          w_next_state = c_WAIT;
          w_next_cnt   = c_WAIT_INIT;
        end else if (w_accept) begin
          w_next_state = c_ERR1;
        end else begin
          w_next_state = c_IDLE;
        end
      end
      c_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_next_state = c_DATA;
        end else begin
          w_next_cnt = r_cnt - 4'd1;
        end
      end
      c_ERR1:  w_next_state = c_ERR2;
      default: w_next_state = c_IDLE;
    endcase
  end

  always_comb begin
    hreadyout = 1'b1;
    hresp     = 1'b0;
    case (r_state)
      c_WAIT: hreadyout = 1'b0;
      c_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
      end
      c_ERR2:  hresp = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      r_addr_q      <= 2'd0;
      r_write_q     <= 1'b0;
      r_size_q      <= 3'd0;
      r_read_select <= 2'd0;
      r_rd_strobe   <= 1'b0;
      r_wr_en       <= 1'b0;
      r_wr_addr     <= 2'd0;
      r_wr_data     <= 8'd0;
      r_err_status  <= 2'd0;
    end else begin
      if (w_accept) begin
        r_addr_q  <= haddr[1:0];
        r_write_q <= hwrite;
        r_size_q  <= hsize;
      end
      r_rd_strobe <= w_accept && w_legal && !hwrite;
      if (w_accept && w_legal && !hwrite) begin
        r_read_select <= haddr[1:0];
      end
      // Write data is only valid on the bus during the final data-phase cycle.
      r_wr_en <= w_data_end && r_write_q;
      if (w_data_end && r_write_q) begin
        r_wr_addr <= r_addr_q;
        r_wr_data <= hwdata;
      end
      if (w_accept && !w_legal) begin
        r_err_status <= w_code;
      end else if (w_data_end && !r_write_q && (r_addr_q == 2'd0) && (r_size_q == 3'd0)) begin
        r_err_status <= 2'd0;
      end
    end
  end

  assign read_select = r_read_select;
  assign rd_strobe   = r_rd_strobe;
  assign wr_en       = r_wr_en;
  assign wr_addr     = r_wr_addr;
  assign wr_data     = r_wr_data;
  assign err_status  = r_err_status;

endmodule
`default_nettype wire

// File: tb/tb_ahb_slave_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_ahb_slave_ctrl
// Brief   : Two instances (1 and 3 wait states) on a shared bus, checked each
//           cycle against a data-phase-countdown reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ahb_slave_ctrl;

  localparam int WS0 = 1;
  localparam int WS1 = 3;

  logic       hclk = 1'b0;
  logic       hreset_n;
  logic       hsel_x;
  logic [7:0] haddr;
  logic [1:0] htrans;
  logic       hwrite;
  logic [2:0] hsize;
  logic       hready;
  logic [7:0] hwdata;

  logic       ro   [2];
  logic       rsp  [2];
  logic [1:0] rsel [2];
  logic       rds  [2];
  logic       wen  [2];
  logic [1:0] wa   [2];
  logic [7:0] wd   [2];
  logic [1:0] est  [2];

  always #5 hclk = ~hclk;

  ahb_slave_ctrl #(.ADDR_W(8), .WAIT_STATES(WS0)) dut0 (
    .hclk(hclk), .hreset_n(hreset_n), .hsel_x(hsel_x), .haddr(haddr),
    .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hready(hready),
    .hwdata(hwdata), .hreadyout(ro[0]), .hresp(rsp[0]),
    .read_select(rsel[0]), .rd_strobe(rds[0]), .wr_en(wen[0]),
    .wr_addr(wa[0]), .wr_data(wd[0]), .err_status(est[0])
  );

  ahb_slave_ctrl #(.ADDR_W(8), .WAIT_STATES(WS1)) dut1 (
    .hclk(hclk), .hreset_n(hreset_n), .hsel_x(hsel_x), .haddr(haddr),
    .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hready(hready),
    .hwdata(hwdata), .hreadyout(ro[1]), .hresp(rsp[1]),
    .read_select(rsel[1]), .rd_strobe(rds[1]), .wr_en(wen[1]),
    .wr_addr(wa[1]), .wr_data(wd[1]), .err_status(est[1])
  );

  // Model: each transfer owns a data phase of known length; the slave is
  // ready only in its last cycle (or when no phase is in progress).
  int         ws_of  [2];
  int         m_left [2];
  bit         m_err  [2];
  bit         m_wr   [2];
  logic [1:0] m_a    [2];
  logic [1:0] m_rsel [2];
  bit         m_rds  [2];
  bit         m_wen  [2];
  logic [1:0] m_wa   [2];
  logic [7:0] m_wd   [2];
  logic [1:0] m_est  [2];
  bit         acc_now[2];

  int n_pass  = 0;
  int n_total = 0;
  int focus   = 0;
  bit auto_rdy = 1'b1;

  function automatic bit m_ready(int i);
    return m_left[i] <= 1;
  endfunction

  function automatic logic [1:0] rule_code();
    if (haddr[7:2] != 6'd0) return 2'd1;
    if (hsize != 3'd0) return 2'd2;
    if (hwrite && (haddr[1:0] == 2'd0 || haddr[1:0] == 2'd3)) return 2'd3;
    return 2'd0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_left[i] = 0; m_err[i] = 0; m_wr[i] = 0; m_a[i] = 0; m_rsel[i] = 0;
      m_rds[i] = 0; m_wen[i] = 0; m_wa[i] = 0; m_wd[i] = 0; m_est[i] = 0;
    end
  endtask

  task automatic chk(string tag, int i, logic [7:0] obs, logic [7:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, i, obs, exp);
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk("hreadyout", i, 8'(ro[i]), 8'(m_ready(i)));
      chk("hresp", i, 8'(rsp[i]), 8'(m_err[i] && m_left[i] > 0));
      chk("read_select", i, 8'(rsel[i]), 8'(m_rsel[i]));
      chk("rd_strobe", i, 8'(rds[i]), 8'(m_rds[i]));
      chk("wr_en", i, 8'(wen[i]), 8'(m_wen[i]));
      chk("wr_addr", i, 8'(wa[i]), 8'(m_wa[i]));
      chk("wr_data", i, wd[i], m_wd[i]);
      chk("err_status", i, 8'(est[i]), 8'(m_est[i]));
    end
  endtask

  task automatic tick();
    logic [1:0] code;
    bit         acc   [2];
    int         n_left[2];
    bit         n_err [2];
    bit         n_wr  [2];
    logic [1:0] n_a   [2];
    logic [1:0] n_rsel[2];
    bit         n_rds [2];
    bit         n_wen [2];
    logic [1:0] n_wa  [2];
    logic [7:0] n_wd  [2];
    logic [1:0] n_est [2];
    if (auto_rdy) hready = m_ready(focus);
    code = rule_code();
    for (int i = 0; i < 2; i++) begin
      bit ending;
      acc[i]  = m_ready(i) && hsel_x && hready && htrans[1];
      ending  = (m_left[i] == 1) && !m_err[i];
      n_wen[i] = ending && m_wr[i];
      n_wa[i]  = n_wen[i] ? m_a[i] : m_wa[i];
      n_wd[i]  = n_wen[i] ? hwdata : m_wd[i];
      n_rds[i] = acc[i] && code == 2'd0 && !hwrite;
      n_rsel[i] = n_rds[i] ? haddr[1:0] : m_rsel[i];
      n_est[i] = m_est[i];
      if (ending && !m_wr[i] && m_a[i] == 2'd0) n_est[i] = 2'd0;
      if (acc[i] && code != 2'd0) n_est[i] = code;
      n_left[i] = acc[i] ? ((code == 2'd0) ? ws_of[i] + 1 : 2)
                         : ((m_left[i] > 0) ? m_left[i] - 1 : 0);
      n_err[i] = acc[i] ? (code != 2'd0) : m_err[i];
      n_wr[i]  = acc[i] ? hwrite : m_wr[i];
      n_a[i]   = acc[i] ? haddr[1:0] : m_a[i];
    end
    @(posedge hclk);
    if (!hreset_n) begin
      model_reset();
      acc_now[0] = 0;
      acc_now[1] = 0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_left[i] = n_left[i]; m_err[i] = n_err[i]; m_wr[i] = n_wr[i];
        m_a[i] = n_a[i]; m_rsel[i] = n_rsel[i]; m_rds[i] = n_rds[i];
        m_wen[i] = n_wen[i]; m_wa[i] = n_wa[i]; m_wd[i] = n_wd[i];
        m_est[i] = n_est[i]; acc_now[i] = acc[i];
      end
    end
    #1;
    check_all();
  endtask

  task automatic xfer(bit w, logic [7:0] a, logic [2:0] sz, logic [7:0] wdat, bit b2b);
    int n = 0;
    hsel_x = 1'b1; htrans = 2'b10; hwrite = w; haddr = a; hsize = sz;
    do begin
      tick();
      n++;
    end while (!acc_now[focus] && n < 20);
    n_total = n_total + 1;
    assert (acc_now[focus]) n_pass = n_pass + 1;
    else $error("FAIL accept_timeout dut%0d observed=%0d expected=1", focus, acc_now[focus]);
    hwdata = wdat;
    if (!b2b) htrans = 2'b00;
  endtask

  task automatic wait_idle();
    int n = 0;
    htrans = 2'b00;
    while ((m_left[0] != 0 || m_left[1] != 0) && n < 40) begin
      tick();
      n++;
    end
    tick();
  endtask

  initial begin
    ws_of[0] = WS0;
    ws_of[1] = WS1;
    hreset_n = 1'b0; hsel_x = 1'b0; haddr = 8'd0; htrans = 2'b00;
    hwrite = 1'b0; hsize = 3'd0; hready = 1'b1; hwdata = 8'd0;
    model_reset();
    repeat (3) tick();
    hreset_n = 1'b1;

    hsel_x = 1'b1;
    htrans = 2'b00;
    repeat (5) tick();

    focus = 0;
    xfer(1'b0, 8'h02, 3'd0, 8'h00, 1'b0);
    wait_idle();
    chk("read_sel_2", 0, 8'(rsel[0]), 8'd2);

    xfer(1'b1, 8'h01, 3'd0, 8'hA5, 1'b0);
    wait_idle();
    for (int i = 0; i < 2; i++) begin
      chk("wr_addr_1", i, 8'(wa[i]), 8'd1);
      chk("wr_data_a5", i, wd[i], 8'hA5);
    end

    xfer(1'b1, 8'h00, 3'd0, 8'h5A, 1'b0);
    wait_idle();
    for (int i = 0; i < 2; i++) chk("err_ro_write", i, 8'(est[i]), 8'd3);

    xfer(1'b0, 8'h10, 3'd0, 8'h00, 1'b0);
    wait_idle();
    for (int i = 0; i < 2; i++) chk("err_range", i, 8'(est[i]), 8'd1);

    xfer(1'b0, 8'h00, 3'd1, 8'h00, 1'b0);
    wait_idle();
    for (int i = 0; i < 2; i++) chk("err_size", i, 8'(est[i]), 8'd2);

    xfer(1'b0, 8'h00, 3'd0, 8'h00, 1'b0);
    wait_idle();
    for (int i = 0; i < 2; i++) begin
      chk("err_cleared", i, 8'(est[i]), 8'd0);
      chk("read_sel_0", i, 8'(rsel[i]), 8'd0);
    end

    focus = 1;
    xfer(1'b0, 8'h01, 3'd0, 8'h00, 1'b1);
    xfer(1'b0, 8'h02, 3'd0, 8'h00, 1'b0);
    wait_idle();
    chk("b2b_read_sel", 1, 8'(rsel[1]), 8'd2);

    focus = 0;
    xfer(1'b1, 8'h01, 3'd0, 8'h3C, 1'b0);
    #3;
    hreset_n = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < 2; i++) chk("async_reset_ready", i, 8'(ro[i]), 8'd1);
    check_all();
    tick();
    hreset_n = 1'b1;
    repeat (6) tick();

    for (int k = 0; k < 400; k++) begin
      hsel_x = ($urandom_range(0, 7) != 0);
      htrans = 2'($urandom);
      hwrite = 1'($urandom);
      haddr  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
      hsize  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      hwdata = 8'($urandom);
      focus  = $urandom_range(0, 1);
      auto_rdy = ($urandom_range(0, 7) != 0);
      if (!auto_rdy) hready = 1'($urandom);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
